// File: rtl/dbd_zone_stat_unit_if.sv
// Pixel-in / zone-statistic-out bundle for the dimming zone statistics unit.
// Latency: none, wires only.
// Backpressure: oZoneValid/iZoneReady handshake on the zone stream; the pixel side cannot be stalled.
interface dbd_zone_stat_unit_if;
    logic        iDE;
    logic        iVSYNC;
    logic [23:0] iQE;
    logic        iMode;
    logic        iZoneReady;
    logic        oZoneValid;
    logic [7:0]  oZoneData;
    logic [3:0]  oZoneH;
    logic [3:0]  oZoneV;
    logic        oALG_rst;
    logic        oFrameDone;
    logic        oOverrun;

    // master: pixel source and zone consumer; slave: the statistics unit
    modport master (
        output iDE, iVSYNC, iQE, iMode, iZoneReady,
        input  oZoneValid, oZoneData, oZoneH, oZoneV, oALG_rst, oFrameDone, oOverrun
    );
    modport slave (
        input  iDE, iVSYNC, iQE, iMode, iZoneReady,
        output oZoneValid, oZoneData, oZoneH, oZoneV, oALG_rst, oFrameDone, oOverrun
    );
endinterface

// File: rtl/dbd_zone_stat_unit.sv
// Zone statistics for backlight dimming: per-zone peak or mean luma, streamed one zone row at a time.
// Latency: first beat of a row is valid two cycles after the DE fall that completes the row.
// Backpressure: beats hold while ready is low; a row completing while readout is busy is dropped and flagged.
module dbd_zone_stat_unit #(
    parameter int H_ZONES     = 8,
    parameter int V_ZONES     = 6,
    parameter int ZONE_W_LOG2 = 7,
    parameter int ZONE_H_LOG2 = 7
) (
    input  logic                iODCK,
    input  logic                iRST,
    dbd_zone_stat_unit_if.slave zs
);
    localparam int SUM_W = 8 + ZONE_W_LOG2 + ZONE_H_LOG2;
    localparam int X_W   = ZONE_W_LOG2 + 5;
    localparam int Y_W   = ZONE_H_LOG2 + 5;
    localparam logic [X_W-1:0] X_LIM = X_W'(H_ZONES << ZONE_W_LOG2);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(V_ZONES << ZONE_H_LOG2);

    typedef enum logic { WAIT_VS, ACTIVE } cap_state_e;
    typedef enum logic { RD_IDLE, RD_RUN } rd_state_e;

    logic             vs_q, vs_d;
    logic             de_q, de_d;
    cap_state_e       cap_q, cap_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic             mode_q, mode_d;
    logic             acc_sel_q, acc_sel_d;
    logic [7:0]       max_q [2][H_ZONES];
    logic [7:0]       max_d [2][H_ZONES];
    logic [SUM_W-1:0] sum_q [2][H_ZONES];
    logic [SUM_W-1:0] sum_d [2][H_ZONES];
    logic             start_q, start_d;
    logic [3:0]       row_q, row_d;
    rd_state_e        rd_q, rd_d;
    logic             valid_q, valid_d;
    logic [7:0]       data_q, data_d;
    logic [3:0]       h_q, h_d;
    logic [3:0]       v_q, v_d;
    logic             alg_rst_q, alg_rst_d;
    logic             frame_done_q, frame_done_d;
    logic             overrun_q, overrun_d;

    logic             frame_start, de_rise, de_fall, row_done, rd_busy, xfer, in_win;
    logic [X_W-1:0]   x_cur;
    logic [7:0]       pix_r, pix_g, pix_b, pix_max, pix_mean, pix_luma;
    logic [9:0]       pix_sum;
    logic             rd_bank;
    logic [7:0]       rd_stat [H_ZONES];
    logic [3:0]       nxt_h;
    logic [7:0]       nxt_stat;

    always_comb begin
        frame_start = zs.iVSYNC & ~vs_q;
        de_rise     = zs.iDE & ~de_q;
        de_fall     = ~zs.iDE & de_q;
        x_cur       = de_rise ? '0 : x_q;
        in_win      = (x_cur < X_LIM) && (y_q < Y_LIM);
        row_done    = de_fall && (y_q[ZONE_H_LOG2-1:0] == '1) && (y_q < Y_LIM);
        rd_busy     = (rd_q != RD_IDLE) || start_q;
        xfer        = valid_q & zs.iZoneReady;
        rd_bank     = ~acc_sel_q;
    end

    // mean luma weights green twice; the 10-bit sum cannot overflow
    always_comb begin
        pix_r    = zs.iQE[23:16];
        pix_g    = zs.iQE[15:8];
        pix_b    = zs.iQE[7:0];
        pix_sum  = {2'b00, pix_r} + {1'b0, pix_g, 1'b0} + {2'b00, pix_b};
        pix_mean = 8'(pix_sum >> 2);
        pix_max  = (pix_r > pix_g) ? pix_r : pix_g;
        if (pix_b > pix_max) pix_max = pix_b;
        pix_luma = mode_q ? pix_mean : pix_max;
    end

    always_comb begin
        for (int c = 0; c < H_ZONES; c++) begin
            rd_stat[c] = mode_q ? sum_q[rd_bank][c][SUM_W-1 -: 8] : max_q[rd_bank][c];
        end
        nxt_h    = start_q ? 4'd0 : 4'(h_q + 4'd1);
        nxt_stat = '0;
        for (int c = 0; c < H_ZONES; c++) begin
            if (4'(c) == nxt_h) nxt_stat = rd_stat[c];
        end
    end

    always_comb begin
        vs_d         = zs.iVSYNC;
        de_d         = zs.iDE;
        cap_d        = cap_q;
        x_d          = x_q;
        y_d          = y_q;
        mode_d       = mode_q;
        acc_sel_d    = acc_sel_q;
        max_d        = max_q;
        sum_d        = sum_q;
        start_d      = start_q;
        row_d        = row_q;
        rd_d         = rd_q;
        valid_d      = valid_q;
        data_d       = data_q;
        h_d          = h_q;
        v_d          = v_q;
        alg_rst_d    = 1'b0;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;

        if (frame_start) begin
            // a new frame discards any partial row and aborts readout
            alg_rst_d = 1'b1;
            cap_d     = ACTIVE;
            x_d       = '0;
            y_d       = '0;
            mode_d    = zs.iMode;
            overrun_d = 1'b0;
            max_d     = '{default: '0};
            sum_d     = '{default: '0};
            start_d   = 1'b0;
            rd_d      = RD_IDLE;
            valid_d   = 1'b0;
        end else begin
            if (cap_q == ACTIVE && zs.iDE) begin
                x_d = (x_cur == '1) ? x_cur : x_cur + 1'b1;
                if (in_win) begin
                    for (int c = 0; c < H_ZONES; c++) begin
                        if (int'(x_cur >> ZONE_W_LOG2) == c) begin
                            if (pix_luma > max_q[acc_sel_q][c]) max_d[acc_sel_q][c] = pix_luma;
                            sum_d[acc_sel_q][c] = sum_q[acc_sel_q][c] + SUM_W'(pix_luma);
                        end
                    end
                end
            end

            if (cap_q == ACTIVE && de_fall) begin
                y_d = (y_q == '1) ? y_q : y_q + 1'b1;
                if (row_done) begin
                    if (!rd_busy) begin
                        acc_sel_d = ~acc_sel_q;
                        for (int c = 0; c < H_ZONES; c++) begin
                            max_d[~acc_sel_q][c] = '0;
                            sum_d[~acc_sel_q][c] = '0;
                        end
                        start_d = 1'b1;
                        row_d   = 4'(y_q >> ZONE_H_LOG2);
                    end else begin
                        for (int c = 0; c < H_ZONES; c++) begin
                            max_d[acc_sel_q][c] = '0;
                            sum_d[acc_sel_q][c] = '0;
                        end
                        overrun_d = 1'b1;
                    end
                    if (int'(y_q >> ZONE_H_LOG2) == V_ZONES - 1) cap_d = WAIT_VS;
                end
            end

            if (start_q) begin
                start_d = 1'b0;
                rd_d    = RD_RUN;
                valid_d = 1'b1;
                h_d     = 4'd0;
                v_d     = row_q;
                data_d  = nxt_stat;
            end else if (rd_q == RD_RUN && xfer) begin
                if (h_q == 4'(H_ZONES - 1)) begin
                    rd_d    = RD_IDLE;
                    valid_d = 1'b0;
                    if (v_q == 4'(V_ZONES - 1)) frame_done_d = 1'b1;
                end else begin
                    h_d    = nxt_h;
                    data_d = nxt_stat;
                end
            end
        end
    end

    always_ff @(posedge iODCK) begin
        if (iRST) begin
            vs_q         <= 1'b0;
            de_q         <= 1'b0;
            cap_q        <= WAIT_VS;
            x_q          <= '0;
            y_q          <= '0;
            mode_q       <= 1'b0;
            acc_sel_q    <= 1'b0;
            max_q        <= '{default: '0};
            sum_q        <= '{default: '0};
            start_q      <= 1'b0;
            row_q        <= '0;
            rd_q         <= RD_IDLE;
            valid_q      <= 1'b0;
            data_q       <= '0;
            h_q          <= '0;
            v_q          <= '0;
            alg_rst_q    <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            vs_q         <= vs_d;
            de_q         <= de_d;
            cap_q        <= cap_d;
            x_q          <= x_d;
            y_q          <= y_d;
            mode_q       <= mode_d;
            acc_sel_q    <= acc_sel_d;
            max_q        <= max_d;
            sum_q        <= sum_d;
            start_q      <= start_d;
            row_q        <= row_d;
            rd_q         <= rd_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            h_q          <= h_d;
            v_q          <= v_d;
            alg_rst_q    <= alg_rst_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign zs.oZoneValid = valid_q;
    assign zs.oZoneData  = data_q;
    assign zs.oZoneH     = h_q;
    assign zs.oZoneV     = v_q;
    assign zs.oALG_rst   = alg_rst_q;
    assign zs.oFrameDone = frame_done_q;
    assign zs.oOverrun   = overrun_q;
endmodule
